// File: rtl/display_scan_ctrl_if.sv
// Display scan bus: scan enable and digit data in, shared-decoder drive and
// digit enables out. The master side feeds values, the slave side is the
// scan controller.
interface display_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  en_in;
  logic [4*DIGITS-1:0]   digits_in;
  logic [DIGITS-1:0]     dp_in;
  logic [3:0]            bcd_out;
  logic                  dp_out;
  logic [DIGITS-1:0]     digit_enable;
  logic                  frame_tick_out;

  modport master (
    output en_in, digits_in, dp_in,
    input  bcd_out, dp_out, digit_enable, frame_tick_out
  );

  modport slave (
    input  en_in, digits_in, dp_in,
    output bcd_out, dp_out, digit_enable, frame_tick_out
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display that
// shares one BCD decoder. Each digit gets BLANK_CYC dead cycles (decoder
// already presented with the next digit, all enables off) followed by
// SHOW_CYC lit cycles. The digit value is snapshotted at the start of every
// frame so a changing input never tears within a frame.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   When defined, digits above digit 0 stay dark while they and every more
//   significant digit are zero with no decimal point requested.
//
// Outputs are registered and reflect the scan position held in the state
// registers during the previous cycle; the shadow value being captured on
// the same edge is forwarded so the first BLANK cycle of a frame already
// presents the freshly sampled digit 0.
module display_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SHOW_CYC  = 50000,
  parameter int BLANK_CYC = 500,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  display_scan_ctrl_if.slave bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    timer_reg, timer_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic                wrap_reg, wrap_next;
  logic [4*DIGITS-1:0] shadow_digits_reg, shadow_digits_next;
  logic [DIGITS-1:0]   shadow_dp_reg, shadow_dp_next;

  logic [3:0]          bcd_reg, bcd_next;
  logic                dp_reg, dp_next;
  logic [DIGITS-1:0]   enable_reg, enable_next;
  logic                tick_reg, tick_next;

  logic                show_phase;
  logic                load;
  logic [IDX_W-1:0]    sel_idx;
  logic [3:0]          digit_val [DIGITS];
  logic [DIGITS-1:0]   lit_mask;

  // With no blanking the BLANK state (reachable only from reset or disable)
  // behaves exactly like the first SHOW cycle.
  assign show_phase = (state_reg == SHOW) || (BLANK_CYC == 0);

  // Capture the inputs while sitting in digit 0's dead time (or, without
  // dead time, on the first cycle of digit 0) and continuously while the
  // scan is disabled.
  assign load = !bus.en_in ||
                ((idx_reg == '0) &&
                 ((BLANK_CYC == 0) ? (timer_reg == '0) : (state_reg == BLANK)));

  assign shadow_digits_next = load ? bus.digits_in : shadow_digits_reg;
  assign shadow_dp_next     = load ? bus.dp_in     : shadow_dp_reg;

  // While disabled the decoder is parked on digit 0.
  assign sel_idx = bus.en_in ? idx_reg : '0;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit_val[gi] = shadow_digits_next[4*gi +: 4];
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] significant;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lzb
      assign significant[gi] = (digit_val[gi] != 4'd0) || shadow_dp_next[gi];
      if (gi == 0) begin : g_lsd
        // Units digit is always lit so a zero value still shows "0".
        assign lit_mask[gi] = 1'b1;
      end else begin : g_upper
        assign lit_mask[gi] = |significant[DIGITS-1:gi];
      end
    end
  endgenerate
`else
  assign lit_mask = '1;
`endif

  // Slot sequencing: dead time, lit time, advance digit, flag frame wrap.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    idx_next   = idx_reg;
    wrap_next  = 1'b0;
    if (!bus.en_in) begin
      state_next = BLANK;
      timer_next = '0;
      idx_next   = '0;
    end else if (show_phase) begin
      if (timer_reg == CNT_W'(SHOW_CYC - 1)) begin
        timer_next = '0;
        state_next = (BLANK_CYC == 0) ? SHOW : BLANK;
        if (idx_reg == IDX_W'(DIGITS - 1)) begin
          idx_next  = '0;
          wrap_next = 1'b1;
        end else begin
          idx_next = idx_reg + IDX_W'(1);
        end
      end else begin
        timer_next = timer_reg + CNT_W'(1);
      end
    end else begin
      if (timer_reg == CNT_W'(BLANK_CYC - 1)) begin
        timer_next = '0;
        state_next = SHOW;
      end else begin
        timer_next = timer_reg + CNT_W'(1);
      end
    end
  end

  // Output values for the scan position currently held in the registers.
  always_comb begin
    bcd_next    = digit_val[sel_idx];
    dp_next     = shadow_dp_next[sel_idx];
    enable_next = '0;
    tick_next   = bus.en_in && wrap_reg;
    if (bus.en_in && show_phase && lit_mask[idx_reg]) begin
      enable_next[idx_reg] = 1'b1;
    end
  end

  // Scan state, frame snapshot and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= BLANK;
      timer_reg         <= '0;
      idx_reg           <= '0;
      wrap_reg          <= 1'b0;
      shadow_digits_reg <= '0;
      shadow_dp_reg     <= '0;
      bcd_reg           <= '0;
      dp_reg            <= 1'b0;
      enable_reg        <= '0;
      tick_reg          <= 1'b0;
    end else begin
      state_reg         <= state_next;
      timer_reg         <= timer_next;
      idx_reg           <= idx_next;
      wrap_reg          <= wrap_next;
      shadow_digits_reg <= shadow_digits_next;
      shadow_dp_reg     <= shadow_dp_next;
      bcd_reg           <= bcd_next;
      dp_reg            <= dp_next;
      enable_reg        <= enable_next;
      tick_reg          <= tick_next;
    end
  end

  assign bus.bcd_out        = bcd_reg;
  assign bus.dp_out         = dp_reg;
  assign bus.digit_enable   = enable_reg;
  assign bus.frame_tick_out = tick_reg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: two instances (with and without dead time)
// share the same stimulus and are compared every cycle against a
// frame-position model that works out slot, offset and snapshot directly
// from the number of cycles since the scan (re)started.
module tb_display_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int SHOW   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp;

  int n_checks = 0;
  int n_fail   = 0;

  display_scan_ctrl_if #(.DIGITS(DIGITS)) bus_a ();
  display_scan_ctrl_if #(.DIGITS(DIGITS)) bus_b ();

  assign bus_a.en_in     = en;
  assign bus_a.digits_in = digits;
  assign bus_a.dp_in     = dp;
  assign bus_b.en_in     = en;
  assign bus_b.digits_in = digits;
  assign bus_b.dp_in     = dp;

  display_scan_ctrl #(.DIGITS(DIGITS), .SHOW_CYC(SHOW), .BLANK_CYC(2), .CNT_W(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  display_scan_ctrl #(.DIGITS(DIGITS), .SHOW_CYC(SHOW), .BLANK_CYC(0), .CNT_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          blank_of [2] = '{2, 0};
  bit          active   [2];
  int          pos      [2];
  logic [15:0] snap     [2];
  logic [3:0]  snap_dp  [2];
  logic [3:0]  e_en     [2];
  logic [3:0]  e_bcd    [2];
  logic        e_dp     [2];
  logic        e_tick   [2];

  function automatic bit lit(int c, int slot);
    bit r;
    r = (slot == 0);
`ifdef LEADING_ZERO_BLANK_EN
    for (int j = slot; j < DIGITS; j++) begin
      if (((snap[c] >> (4 * j)) & 16'hF) != 0 || snap_dp[c][j]) r = 1'b1;
    end
`else
    r = 1'b1;
`endif
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      active[c]  = 1'b0;
      pos[c]     = 0;
      snap[c]    = '0;
      snap_dp[c] = '0;
      e_en[c]    = '0;
      e_bcd[c]   = '0;
      e_dp[c]    = 1'b0;
      e_tick[c]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    int slot_len, period, fp, slot, off;
    for (int c = 0; c < 2; c++) begin
      slot_len = blank_of[c] + SHOW;
      period   = DIGITS * slot_len;
      if (!en) begin
        active[c]  = 1'b0;
        snap[c]    = digits;
        snap_dp[c] = dp;
        e_en[c]    = '0;
        e_tick[c]  = 1'b0;
        e_bcd[c]   = 4'(digits & 16'hF);
        e_dp[c]    = dp[0];
      end else begin
        if (active[c]) pos[c]++;
        else begin
          active[c] = 1'b1;
          pos[c]    = 0;
        end
        fp   = pos[c] % period;
        slot = fp / slot_len;
        off  = fp % slot_len;
        if (fp <= ((blank_of[c] > 0) ? blank_of[c] - 1 : 0)) begin
          snap[c]    = digits;
          snap_dp[c] = dp;
        end
        e_bcd[c]  = 4'((snap[c] >> (4 * slot)) & 16'hF);
        e_dp[c]   = snap_dp[c][slot];
        e_en[c]   = (off >= blank_of[c] && lit(c, slot)) ? 4'(1 << slot) : 4'd0;
        e_tick[c] = (fp == 0) && (pos[c] > 0);
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("enable_a", 32'(bus_a.digit_enable), 32'(e_en[0]));
    check("bcd_a",    32'(bus_a.bcd_out),      32'(e_bcd[0]));
    check("dp_a",     32'(bus_a.dp_out),       32'(e_dp[0]));
    check("tick_a",   32'(bus_a.frame_tick_out), 32'(e_tick[0]));
    check("onehot_a", 32'($countones(bus_a.digit_enable) <= 1), 32'd1);
    check("enable_b", 32'(bus_b.digit_enable), 32'(e_en[1]));
    check("bcd_b",    32'(bus_b.bcd_out),      32'(e_bcd[1]));
    check("dp_b",     32'(bus_b.dp_out),       32'(e_dp[1]));
    check("tick_b",   32'(bus_b.frame_tick_out), 32'(e_tick[1]));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    #2 rst = 1'b0;
    #1 model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hold;
    rst    = 1'b0;
    en     = 1'b1;
    digits = 16'h4321;
    dp     = 4'b0100;
    model_reset();
    #1 compare_all();
    $display("reset state checked at %0t", $time);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    run(10);
    $display("startup: 10 cycles from release, digits=%h", digits);

    digits = 16'h8765;
    run(40);
    $display("tearing: digits changed to %h during digit 1 show", digits);

    run(6);
    en = 1'b0;
    run(5);
    $display("disable held 5 cycles");
    en = 1'b1;
    run(30);
    $display("re-enable: 30 cycles");

    digits = 16'h0050;
    dp     = 4'b0000;
    run(50);
    $display("leading zeros: digits=%h", digits);
    digits = 16'h0000;
    run(50);
    $display("all zero: digits=%h", digits);

    run(9);
    async_reset();
    run(30);
    $display("mid-frame reset and restart");

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       digits = 16'($urandom) & 16'h00FF;
          1:       digits = 16'($urandom) & 16'h000F;
          2:       digits = 16'h0000;
          default: digits = 16'($urandom);
        endcase
        dp = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      end
      if (hold > 0) begin
        hold--;
        if (hold == 0) en = 1'b1;
      end else if ($urandom_range(0, 79) == 0) begin
        en   = 1'b0;
        hold = $urandom_range(1, 8);
      end
      if (i % 600 == 300) async_reset();
      step();
      if (i % 100 == 0)
        $display("random cycle %0d: en=%0b digits=%h dp=%b", i, en, digits, dp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexing scheduler sharing one BCD-to-7-segment decoder among DIGITS common-anode/cathode digit positions.
- Selects one digit per time slot and drives its BCD value and one-hot digit enable.
- Inserts a dead-time blanking interval between digits to prevent ghosting.
- Snapshots the multi-digit value once per frame so a running counter never tears mid-frame.

Parameters:
- DIGITS, 4, number of multiplexed digit positions (2..8); digit 0 is least significant.
- SHOW_CYC, 50000, clock cycles each digit is lit (>=1).
- BLANK_CYC, 500, dead-time cycles with all digits off before each digit (>=0; 0 removes blanking).
- CNT_W, 16, width of the slot timer; must hold max(SHOW_CYC, BLANK_CYC)-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- en_in  in  1  scan enable; low forces all digits off.
- digits_in  in  4*DIGITS  packed BCD values; bits [4i+3:4i] = digit i.
- dp_in  in  DIGITS  decimal-point request per digit.
- bcd_out  out  4  BCD value for the shared decoder.
- dp_out  out  1  decimal point for the selected digit.
- digit_enable  out  DIGITS  one-hot active-high digit select; all-zero when blanking.
- frame_tick_out  out  1  one-cycle pulse at end of each complete frame.

Behaviour:
- All outputs registered. Reset (rst=0, asynchronous, no clock needed): bcd_out=0, dp_out=0, digit_enable=0, frame_tick_out=0, idx=0, timer=0, shadow=0, state=BLANK.
- FSM states: BLANK, SHOW.
- BLANK:
  - digit_enable=0.
  - bcd_out/dp_out already present the value of digit idx, giving decoder setup before lighting.
  - Lasts BLANK_CYC cycles, then goes to SHOW with timer=0.
  - If BLANK_CYC=0, BLANK lasts zero cycles: SHOW follows SHOW directly.
- SHOW:
  - digit_enable = 1<<idx.
  - Lasts SHOW_CYC cycles.
  - On the last cycle, idx <= (idx==DIGITS-1) ? 0 : idx+1, and the FSM enters BLANK.
- frame_tick_out: high for exactly the one cycle following the SHOW->next transition where idx wraps DIGITS-1 -> 0.
- Shadow register (digits_in, dp_in):
  - Loaded on every clock edge while (state==BLANK and idx==0) or en_in=0.
  - For BLANK_CYC=0, loaded on the edge entering digit 0.
  - Frozen for the rest of the frame.
  - bcd_out/dp_out always come from the shadow.
- Frame period = DIGITS*(BLANK_CYC+SHOW_CYC) cycles.
- First cycle after reset release = BLANK cycle 0 of digit 0.
- en_in=0 (sampled synchronously):
  - Next edge forces digit_enable=0, idx=0, timer=0, state=BLANK, frame_tick_out=0.
  - Held there while low.
  - On return to 1, the scan restarts with a full BLANK of digit 0.
- Non-BCD nibbles (10..15) are passed through unchanged; decoding is the decoder's concern.
- Reset mid-frame: immediate clear to reset values; the scan restarts from digit 0 after release.
- At most one bit of digit_enable is set in any cycle.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - During SHOW of digit i (i>0), digit_enable stays 0 if shadow digit i and all higher digits are 0 and dp for those digits is 0.
  - Timing and frame period are unchanged.
  - Digit 0 is always lit.
- Undefined: every digit is lit in its slot regardless of value.

Test Plan:
- Use DIGITS=4, SHOW_CYC=4, BLANK_CYC=2 unless noted.
- Reset/startup: rst=0 -> all outputs 0 with no clock edge. Release with digits_in=16'h4321, en_in=1 -> cycles 0-1 digit_enable=0000 and bcd_out=1; cycles 2-5 digit_enable=0001 and bcd_out=1.
- Full frame: digits_in=16'h4321, dp_in=4'b0100 -> bcd_out sequence 1,2,3,4; enables 0001,0010,0100,1000; dp_out=1 only in digit 2's slots; frame_tick_out pulses once every 24 cycles.
- Tearing: digits_in changes to 16'h8765 during digit 1 SHOW -> digits 2,3 still show 3,4; next frame shows 5,6,7,8.
- Enable: en_in=0 mid-SHOW of digit 2 -> digit_enable=0000 next cycle and stays there. en_in=1 -> 2 blank cycles, then 0001 showing the current digits_in low nibble.
- No blanking: BLANK_CYC=0 -> digit_enable never 0000 while enabled; 16-cycle frame; frame_tick_out every 16 cycles.
- Leading zeros, with LEADING_ZERO_BLANK_EN: digits_in=16'h0050 -> digits 0,1 lit (0 and 5), digits 2,3 enable stays 0000, period still 24. With digits_in=16'h0000 only digit 0 lit. Without the macro, all four digits are lit.
